// File: rtl/controller_link_ctrl.sv
// UART gamepad link controller: parses 3-byte frames (header, buttons, checksum),
// supervises the link with gap and watchdog timers, and merges pad and board buttons.
module controller_link_ctrl #(
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int unsigned GAP_CYCLES   = 100_000,
    parameter int unsigned LINK_TIMEOUT = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [6:0] board_btn,
    output logic [6:0] buttons,
    output logic       controllerConnected,
    output logic [7:0] frame_err_count
);

    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int unsigned WDOG_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(LINK_TIMEOUT);

    typedef enum logic [1:0] {
        WAIT_HDR = 2'd0,
        GOT_HDR  = 2'd1,
        GOT_BTN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_stage;
    logic [GAP_W-1:0]  r_gap;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_link_ok;
    logic [6:0]        r_ctrl_btn;
    logic              r_ctrl_paired;
    logic [7:0]        r_err_cnt;

    logic w_sum_ok;
    logic w_commit;
    logic w_bad_sum;
    logic w_gap_exp;
    logic w_error;
    logic w_wdog_exp;
    logic w_conn;

    // A byte arriving in the expiry cycle takes priority over the gap timeout.
    assign w_sum_ok   = (rx_data == (HEADER ^ r_stage));
    assign w_commit   = rx_valid && (r_state == GOT_BTN) && w_sum_ok;
    assign w_bad_sum  = rx_valid && (r_state == GOT_BTN) && !w_sum_ok;
    assign w_gap_exp  = !rx_valid && (r_state != WAIT_HDR) && (r_gap == GAP_MAX);
    assign w_error    = w_bad_sum || w_gap_exp;
    assign w_wdog_exp = (r_wdog == WDOG_MAX);
    assign w_conn     = r_link_ok && r_ctrl_paired;

    // Frame parser FSM with staging register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_HDR;
            r_stage <= 8'h00;
        end else begin
            case (r_state)
                WAIT_HDR: begin
                    if (rx_valid && (rx_data == HEADER)) begin
                        r_state <= GOT_HDR;
                    end
                end
                GOT_HDR: begin
                    if (rx_valid) begin
                        r_stage <= rx_data;
                        r_state <= GOT_BTN;
                    end else if (w_gap_exp) begin
                        r_state <= WAIT_HDR;
                    end
                end
                GOT_BTN: begin
                    if (rx_valid || w_gap_exp) begin
                        r_state <= WAIT_HDR;
                    end
                end
                default: r_state <= WAIT_HDR;
            endcase
        end
    end

    // Inter-byte gap timer, idle outside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if (rx_valid || (r_state == WAIT_HDR) || w_gap_exp) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + GAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'h00;
        end else if (w_error && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Committed pad state and link watchdog; a commit beats a coinciding expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog        <= '0;
            r_link_ok     <= 1'b0;
            r_ctrl_btn    <= 7'h00;
            r_ctrl_paired <= 1'b0;
        end else if (w_commit) begin
            r_wdog        <= '0;
            r_link_ok     <= 1'b1;
            r_ctrl_btn    <= r_stage[7] ? r_stage[6:0] : 7'h00;
            r_ctrl_paired <= r_stage[7];
        end else if (w_wdog_exp) begin
            r_link_ok     <= 1'b0;
            r_ctrl_btn    <= 7'h00;
            r_ctrl_paired <= 1'b0;
        end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons             <= 7'h00;
            controllerConnected <= 1'b0;
        end else begin
            buttons             <= board_btn | (w_conn ? r_ctrl_btn : 7'h00);
            controllerConnected <= w_conn;
        end
    end

    assign frame_err_count = r_err_cnt;

endmodule

// File: tb/tb_controller_link_ctrl.sv
// Directed bench for controller_link_ctrl with shortened gap and watchdog timers.
module tb_controller_link_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [6:0] board_btn;
    logic [6:0] buttons;
    logic       controllerConnected;
    logic [7:0] frame_err_count;

    int n_vec;
    int n_err;

    controller_link_ctrl #(
        .HEADER      (8'hA5),
        .GAP_CYCLES  (16),
        .LINK_TIMEOUT(64)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .board_btn          (board_btn),
        .buttons            (buttons),
        .controllerConnected(controllerConnected),
        .frame_err_count    (frame_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic test_reset;
        n_vec++; if (buttons !== 7'h00) begin n_err++; $display("FAIL reset_buttons got=%h exp=00", buttons); end
        n_vec++; if (controllerConnected !== 1'b0) begin n_err++; $display("FAIL reset_conn got=%b exp=0", controllerConnected); end
        n_vec++; if (frame_err_count !== 8'h00) begin n_err++; $display("FAIL reset_err got=%h exp=00", frame_err_count); end
    endtask

    task automatic test_good_frame;
        send_frame(8'hA5, 8'h49, 8'hEC);
        tick(1);
        n_vec++; if (buttons !== 7'h00) begin n_err++; $display("FAIL unpaired_buttons got=%h exp=00", buttons); end
        n_vec++; if (controllerConnected !== 1'b0) begin n_err++; $display("FAIL unpaired_conn got=%b exp=0", controllerConnected); end
        n_vec++; if (frame_err_count !== 8'h00) begin n_err++; $display("FAIL unpaired_err got=%h exp=00", frame_err_count); end
        send_frame(8'hA5, 8'h85, 8'h20);
        n_vec++; if (buttons !== 7'h00) begin n_err++; $display("FAIL latency_early got=%h exp=00", buttons); end
        tick(1);
        n_vec++; if (buttons !== 7'h05) begin n_err++; $display("FAIL paired_buttons got=%h exp=05", buttons); end
        n_vec++; if (controllerConnected !== 1'b1) begin n_err++; $display("FAIL paired_conn got=%b exp=1", controllerConnected); end
    endtask

    task automatic test_bad_checksum;
        send_frame(8'hA5, 8'h83, 8'h00);
        tick(1);
        n_vec++; if (buttons !== 7'h05) begin n_err++; $display("FAIL badsum_buttons got=%h exp=05", buttons); end
        n_vec++; if (frame_err_count !== 8'd1) begin n_err++; $display("FAIL badsum_err got=%h exp=01", frame_err_count); end
        send_frame(8'hA5, 8'h81, 8'h24);
        tick(1);
        n_vec++; if (buttons !== 7'h01) begin n_err++; $display("FAIL after_badsum_buttons got=%h exp=01", buttons); end
    endtask

    task automatic test_hdr_as_data;
        send_frame(8'hA5, 8'hA5, 8'h00);
        tick(1);
        n_vec++; if (buttons !== 7'h25) begin n_err++; $display("FAIL hdr_data_buttons got=%h exp=25", buttons); end
        n_vec++; if (frame_err_count !== 8'd1) begin n_err++; $display("FAIL hdr_data_err got=%h exp=01", frame_err_count); end
    endtask

    task automatic test_gap_timeout;
        send_byte(8'hA5);
        send_byte(8'h81);
        tick(20);
        send_byte(8'h24);
        tick(1);
        n_vec++; if (frame_err_count !== 8'd2) begin n_err++; $display("FAIL gap_err got=%h exp=02", frame_err_count); end
        n_vec++; if (buttons !== 7'h25) begin n_err++; $display("FAIL gap_buttons got=%h exp=25", buttons); end
        send_frame(8'hA5, 8'h82, 8'h27);
        tick(1);
        n_vec++; if (buttons !== 7'h02) begin n_err++; $display("FAIL after_gap_buttons got=%h exp=02", buttons); end
    endtask

    task automatic test_gap_boundary;
        send_byte(8'hA5);
        send_byte(8'h83);
        tick(16);
        send_byte(8'h26);
        tick(1);
        n_vec++; if (buttons !== 7'h03) begin n_err++; $display("FAIL gap_edge_buttons got=%h exp=03", buttons); end
        n_vec++; if (frame_err_count !== 8'd2) begin n_err++; $display("FAIL gap_edge_err got=%h exp=02", frame_err_count); end
    endtask

    task automatic test_watchdog;
        send_frame(8'hA5, 8'h8F, 8'h2A);
        tick(1);
        n_vec++; if (controllerConnected !== 1'b1) begin n_err++; $display("FAIL wd_conn_up got=%b exp=1", controllerConnected); end
        n_vec++; if (buttons !== 7'h0F) begin n_err++; $display("FAIL wd_buttons_up got=%h exp=0f", buttons); end
        tick(63);
        n_vec++; if (controllerConnected !== 1'b1) begin n_err++; $display("FAIL wd_before_expiry got=%b exp=1", controllerConnected); end
        tick(2);
        n_vec++; if (controllerConnected !== 1'b0) begin n_err++; $display("FAIL wd_expired_conn got=%b exp=0", controllerConnected); end
        n_vec++; if (buttons !== 7'h00) begin n_err++; $display("FAIL wd_expired_buttons got=%h exp=00", buttons); end
        send_frame(8'hA5, 8'h8F, 8'h2A);
        tick(1);
        n_vec++; if (controllerConnected !== 1'b1) begin n_err++; $display("FAIL wd_restored_conn got=%b exp=1", controllerConnected); end
        n_vec++; if (buttons !== 7'h0F) begin n_err++; $display("FAIL wd_restored_buttons got=%h exp=0f", buttons); end
    endtask

    task automatic test_merge;
        board_btn = 7'h08;
        send_frame(8'hA5, 8'h84, 8'h21);
        tick(1);
        n_vec++; if (buttons !== 7'h0C) begin n_err++; $display("FAIL merge_buttons got=%h exp=0c", buttons); end
        board_btn = 7'h40;
        tick(1);
        n_vec++; if (buttons !== 7'h44) begin n_err++; $display("FAIL board_change got=%h exp=44", buttons); end
        board_btn = 7'h00;
        tick(1);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            send_frame(8'hA5, 8'h80, 8'h00);
        end
        tick(1);
        n_vec++; if (frame_err_count !== 8'hFF) begin n_err++; $display("FAIL err_saturate got=%h exp=ff", frame_err_count); end
    endtask

    task automatic test_reset_midframe;
        send_frame(8'hA5, 8'h84, 8'h21);
        tick(1);
        n_vec++; if (buttons !== 7'h04) begin n_err++; $display("FAIL pre_reset_buttons got=%h exp=04", buttons); end
        send_byte(8'hA5);
        send_byte(8'h9F);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (buttons !== 7'h00) begin n_err++; $display("FAIL async_rst_buttons got=%h exp=00", buttons); end
        n_vec++; if (controllerConnected !== 1'b0) begin n_err++; $display("FAIL async_rst_conn got=%b exp=0", controllerConnected); end
        n_vec++; if (frame_err_count !== 8'h00) begin n_err++; $display("FAIL async_rst_err got=%h exp=00", frame_err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        send_byte(8'h3A);
        tick(1);
        n_vec++; if (frame_err_count !== 8'h00) begin n_err++; $display("FAIL stray_byte_err got=%h exp=00", frame_err_count); end
        n_vec++; if (buttons !== 7'h00) begin n_err++; $display("FAIL stray_byte_buttons got=%h exp=00", buttons); end
        send_frame(8'hA5, 8'h9F, 8'h3A);
        tick(1);
        n_vec++; if (buttons !== 7'h1F) begin n_err++; $display("FAIL post_reset_buttons got=%h exp=1f", buttons); end
        n_vec++; if (controllerConnected !== 1'b1) begin n_err++; $display("FAIL post_reset_conn got=%b exp=1", controllerConnected); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        board_btn = 7'h00;
        tick(3);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_hdr_as_data();
        test_gap_timeout();
        test_gap_boundary();
        test_watchdog();
        test_merge();
        test_saturation();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
